// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic RV32I/M fields into machine words and writes them sequentially into instruction memory.
// Optional macro ENC_NOP_PAD_EN fills the slots after the last instruction with NOPs.
module instr_encoder_loader #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [3:0]                 op,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [31:0]                imm,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       err,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR
`ifdef ENC_NOP_PAD_EN
    , S_PAD
`endif
  } state_t;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [31:0] word, enc;
  logic last, legal, hs, at_end, i_ok, b_ok, j_ok;
  logic [2:0] f3;
  logic signed [31:0] si;
  assign si = $signed(imm);
  assign hs = in_valid & in_ready;
  assign at_end = idx == IW'(DEPTH - 1);
  assign mem_addr = BASE_ADDR + (ADDR_W'(idx) << 2);
`ifdef ENC_NOP_PAD_EN
  assign mem_wdata = state == S_PAD ? 32'h0000_0013 : word;
`else
  assign mem_wdata = word;
`endif
  always_comb begin
    f3 = op[1:0] == 2'd0 ? 3'b000 : op[1:0] == 2'd1 ? 3'b100 : op[1:0] == 2'd2 ? 3'b110 : 3'b111;
    i_ok = si >= -32'sd2048 && si <= 32'sd2047;
    b_ok = si >= -32'sd4096 && si <= 32'sd4094 && !imm[0];
    j_ok = si >= -32'sd1048576 && si <= 32'sd1048574 && !imm[0];
    enc = '0;
    legal = 1'b0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: begin enc = {imm[11:0], rs1, f3, rd, 7'b0010011}; legal = i_ok; end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin enc = {6'b0, op == 4'd8, rs2, rs1, f3, rd, 7'b0110011}; legal = 1'b1; end
      4'd9: begin enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}; legal = i_ok; end
      4'd10, 4'd11: begin enc = {imm[12], imm[10:5], rs2, rs1, 2'b00, op == 4'd11, imm[4:1], imm[11], 7'b1100011}; legal = b_ok; end
      4'd12: begin enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}; legal = j_ok; end
      4'd13: begin enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; legal = i_ok; end
      default: begin enc = '0; legal = 1'b0; end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: nxt = start ? S_LOAD : state;
      S_LOAD: nxt = !hs ? S_LOAD : legal ? S_WRITE : S_ERR;
`ifdef ENC_NOP_PAD_EN
      S_WRITE: nxt = at_end ? S_DONE : last ? S_PAD : S_LOAD;
      S_PAD: nxt = at_end ? S_DONE : S_PAD;
`else
      S_WRITE: nxt = at_end || last ? S_DONE : S_LOAD;
`endif
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == S_LOAD;
`ifdef ENC_NOP_PAD_EN
    mem_we = state == S_WRITE || state == S_PAD;
`else
    mem_we = state == S_WRITE;
`endif
    cpu_hold = state != S_DONE;
    done = state == S_DONE;
    err = state == S_ERR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      count <= '0;
      full <= 1'b0;
      word <= '0;
      last <= 1'b0;
    end else begin
      if (start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
        idx <= '0;
        count <= '0;
        full <= 1'b0;
      end
      if (hs) begin
        word <= enc;
        last <= in_last;
      end
      if (mem_we) begin
        idx <= idx + 1'b1;
        count <= count + 1'b1;
        full <= full | at_end;
      end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: random and directed programs checked against a field-level encoding model.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  typedef struct {
    logic [3:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    bit last;
  } ins_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
  logic [3:0] op = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic in_ready, mem_we, cpu_hold, done, err, full;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0] count;
  int nvec = 0, nerr = 0;
  ins_t prog[$];
  logic [31:0] wq[$], aq[$];
  always #5 clk = ~clk;
  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .full(full), .count(count)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (mem_we === 1'b1) begin
      wq.push_back(mem_wdata);
      aq.push_back(mem_addr);
      chk("ready_in_write", 32'(in_ready), 0);
    end
  function automatic ins_t mk(int o, int d, int s1, int s2, int im, bit l);
    ins_t p;
    p.op = 4'(o); p.rd = 5'(d); p.rs1 = 5'(s1); p.rs2 = 5'(s2); p.imm = 32'(im); p.last = l;
    return p;
  endfunction
  function automatic logic [31:0] model(ins_t p, output bit ok);
    int v;
    logic [31:0] u, r1, r2, d, f3;
    u = p.imm; v = int'($signed(p.imm));
    r1 = 32'(p.rs1) << 15; r2 = 32'(p.rs2) << 20; d = 32'(p.rd) << 7;
    f3 = (p.op % 4 == 0) ? 0 : (p.op % 4 == 1) ? 4 : (p.op % 4 == 2) ? 6 : 7;
    ok = 1;
    model = 0;
    if (p.op <= 3 || p.op == 13) begin
      ok = v >= -2048 && v <= 2047;
      model = ((u & 32'hFFF) << 20) | r1 | ((p.op == 13 ? 0 : f3) << 12) | d | (p.op == 13 ? 32'h67 : 32'h13);
    end else if (p.op <= 8)
      model = ((p.op == 8 ? 32'd1 : 32'd0) << 25) | r2 | r1 | (f3 << 12) | d | 32'h33;
    else if (p.op == 9) begin
      ok = v >= -2048 && v <= 2047;
      model = (((u >> 5) & 127) << 25) | r2 | r1 | (32'd2 << 12) | ((u & 31) << 7) | 32'h23;
    end else if (p.op <= 11) begin
      ok = v >= -4096 && v <= 4094 && v % 2 == 0;
      model = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | r2 | r1 | ((p.op == 11 ? 32'd1 : 32'd0) << 12)
            | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
    end else if (p.op == 12) begin
      ok = v >= -1048576 && v <= 1048574 && v % 2 == 0;
      model = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | d | 32'h6F;
    end else ok = 0;
  endfunction
  function automatic ins_t rnd_ins(bit l);
    ins_t p;
    bit bad;
    p = mk($urandom_range(0, 13), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, l);
    bad = $urandom_range(0, 9) == 0;
    if (p.op <= 3 || p.op == 9 || p.op == 13) p.imm = bad ? ($urandom_range(0, 1) ? 2048 : -2049) : int'($urandom_range(0, 4095)) - 2048;
    else if (p.op == 10 || p.op == 11) p.imm = (int'($urandom_range(0, 4095)) - 2048) * 2 + (bad ? 1 : 0);
    else if (p.op == 12) p.imm = bad ? 1048576 : (int'($urandom_range(0, 1048575)) - 524288) * 2;
    else p.imm = $urandom;
    if ($urandom_range(0, 24) == 0) p.op = 4'(14 + $urandom_range(0, 1));
    return p;
  endfunction
  task automatic send(ins_t p);
    @(negedge clk);
    in_valid = 1; op = p.op; rd = p.rd; rs1 = p.rs1; rs2 = p.rs2; imm = p.imm; in_last = p.last;
    for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);
    chk("ready_seen", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic run_prog();
    int n;
    bit ok, e;
    logic [31:0] w;
    logic [31:0] eq[$];
    wq.delete(); aq.delete();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("start_err", 32'(err), 0);
    chk("start_ready", 32'(in_ready), 1);
    chk("start_count", 32'(count), 0);
    n = 0; e = 0;
    foreach (prog[i]) begin
      w = model(prog[i], ok);
      send(prog[i]);
      chk("we_latency", 32'(mem_we), 32'(ok));
      if (!ok) begin e = 1; break; end
      eq.push_back(w);
      n++;
      if (prog[i].last || n == DEPTH) break;
    end
`ifdef ENC_NOP_PAD_EN
    if (!e) while (eq.size() < DEPTH) eq.push_back(32'h13);
`endif
    for (int c = 0; c < 40 && !(done || err); c++) @(negedge clk);
    chk("done", 32'(done), 32'(!e));
    chk("err", 32'(err), 32'(e));
    chk("cpu_hold", 32'(cpu_hold), 32'(e));
    chk("in_ready_end", 32'(in_ready), 0);
    chk("full", 32'(full), 32'(eq.size() == DEPTH));
    chk("count", 32'(count), 32'(eq.size()));
    chk("nwrites", 32'(wq.size()), 32'(eq.size()));
    foreach (eq[k])
      if (k < wq.size()) begin
        chk("wdata", wq[k], eq[k]);
        chk("waddr", aq[k], 32'(4 * k));
      end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int len;
    #12;
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    @(negedge clk) rst = 0;
    prog = '{mk(0, 1, 0, 0, 5, 1)};
    run_prog();
    chk("addi_word", wq.size() > 0 ? wq[0] : 32'h0, 32'h00500093);
    prog = '{mk(4, 3, 1, 2, 0, 0), mk(8, 3, 1, 2, 0, 0), mk(9, 0, 1, 2, 8, 1)};
    run_prog();
    chk("add_word", wq.size() > 0 ? wq[0] : 32'h0, 32'h002081B3);
    chk("mul_word", wq.size() > 1 ? wq[1] : 32'h0, 32'h022081B3);
    chk("sw_word", wq.size() > 2 ? wq[2] : 32'h0, 32'h0020A423);
    prog = '{mk(10, 0, 1, 2, -4, 0), mk(12, 1, 0, 0, 8, 1)};
    run_prog();
    chk("beq_word", wq.size() > 0 ? wq[0] : 32'h0, 32'hFE208EE3);
    chk("jal_word", wq.size() > 1 ? wq[1] : 32'h0, 32'h008000EF);
    prog = '{mk(0, 1, 0, 0, 2048, 1)};
    run_prog();
    prog = '{mk(14, 1, 0, 0, 0, 1)};
    run_prog();
    prog = '{mk(10, 0, 1, 2, 3, 1)};
    run_prog();
    prog = '{mk(0, 1, 0, 0, 1, 0), mk(0, 2, 0, 0, 2, 0), mk(0, 3, 0, 0, 3, 0), mk(0, 4, 0, 0, 4, 0)};
    run_prog();
    chk("depth_last_addr", aq.size() > 0 ? aq[aq.size() - 1] : 32'h0, 32'hC);
    wq.delete();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    send(mk(0, 1, 0, 0, 5, 1));
    rst = 1;
    #1;
    chk("midrst_we", 32'(mem_we), 0);
    chk("midrst_hold", 32'(cpu_hold), 1);
    chk("midrst_ready", 32'(in_ready), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("midrst_nowrite", 32'(wq.size()), 0);
    for (int t = 0; t < 40; t++) begin
      prog.delete();
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) prog.push_back(rnd_ins(i == len - 1));
      run_prog();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
